// File: rtl/d_fifo_drain.sv
// Output drain engine: pops the D0/D1 destination FIFOs round-robin and presents
// each word on one registered stream with its source, counts and a route check.
module d_fifo_drain #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              hold,
  input  logic              D0_empty,
  input  logic              D1_empty,
  input  logic [DATA_W-1:0] data_out0,
  input  logic [DATA_W-1:0] data_out1,
  output logic              pop_D0,
  output logic              pop_D1,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  output logic              word_src,
  output logic [CNT_W-1:0]  count_D0,
  output logic [CNT_W-1:0]  count_D1,
  output logic              route_err,
  output logic              drain_idle
);

  localparam int DEST_BIT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              last_served_r;
  logic              in_flight_r;
  logic              flight_src_r;
  logic              pop0_s;
  logic              pop1_s;
  logic [DATA_W-1:0] sel_word_s;

  // A word is misrouted when its destination bit disagrees with the FIFO it came from.
  function automatic logic dest_mismatch(input logic [DATA_W-1:0] word, input logic src);
    return word[DEST_BIT] != src;
  endfunction

  // Next-state decode and round-robin pop selection.
  always_comb begin
    state_next_s = state_r;
    pop0_s       = 1'b0;
    pop1_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && (!D0_empty || !D1_empty)) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = IDLE;
        end
      end
      DRAIN: begin
        if (enable && !hold) begin
          // On a tie the FIFO not served last wins; the empty flags gate every pop.
          if (!D0_empty && !D1_empty) begin
            pop0_s = last_served_r;
            pop1_s = !last_served_r;
          end else begin
            pop0_s = !D0_empty;
            pop1_s = !D1_empty;
          end
        end else begin
          pop0_s = 1'b0;
          pop1_s = 1'b0;
        end
        if (!enable || (D0_empty && D1_empty)) begin
          state_next_s = FLUSH;
        end else begin
          state_next_s = DRAIN;
        end
      end
      FLUSH: begin
        // Any word popped in the last DRAIN cycle is captured on this cycle's edge.
        if (enable && (!D0_empty || !D1_empty)) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  assign pop_D0     = pop0_s;
  assign pop_D1     = pop1_s;
  assign drain_idle = (state_r == IDLE);
  assign sel_word_s = flight_src_r ? data_out1 : data_out0;

  // State, arbitration history and the one-deep capture stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      last_served_r <= 1'b1;
      in_flight_r   <= 1'b0;
      flight_src_r  <= 1'b0;
      word_out      <= '0;
      word_valid    <= 1'b0;
      word_src      <= 1'b0;
      count_D0      <= '0;
      count_D1      <= '0;
      route_err     <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_flight_r <= pop0_s | pop1_s;
      word_valid  <= in_flight_r;
      if (pop0_s || pop1_s) begin
        flight_src_r  <= pop1_s;
        last_served_r <= pop1_s;
      end
      if (in_flight_r) begin
        word_out <= sel_word_s;
        word_src <= flight_src_r;
        if (flight_src_r) begin
          count_D1 <= count_D1 + CNT_W'(1);
        end else begin
          count_D0 <= count_D0 + CNT_W'(1);
        end
        if (dest_mismatch(sel_word_s, flight_src_r)) begin
          route_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_d_fifo_drain.sv
// Directed bench for d_fifo_drain: bench-side FIFOs, a queue-based reference model
// compared every cycle, and literal expectations at the end of each scenario.
module tb_d_fifo_drain;

  localparam int DW = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, enable, hold, D0_empty, D1_empty;
  logic [DW-1:0] data_out0, data_out1;
  logic          pop_D0, pop_D1;
  logic [DW-1:0] word_out;
  logic          word_valid, word_src;
  logic [CW-1:0] count_D0, count_D1;
  logic          route_err, drain_idle;

  always #5 clk = ~clk;

  d_fifo_drain #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .hold(hold),
    .D0_empty(D0_empty), .D1_empty(D1_empty),
    .data_out0(data_out0), .data_out1(data_out1),
    .pop_D0(pop_D0), .pop_D1(pop_D1),
    .word_out(word_out), .word_valid(word_valid), .word_src(word_src),
    .count_D0(count_D0), .count_D1(count_D1),
    .route_err(route_err), .drain_idle(drain_idle)
  );

  // bench FIFO contents
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  // reference model: mode 0 idle, 1 draining, 2 flushing
  int            m_mode;
  logic          m_last, m_pv, m_ps, m_v, m_s, m_err;
  logic [DW-1:0] m_pw, m_w;
  int            m_c0, m_c1;

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_pop0 = 0;
  logic src_log[$];
  logic exp_rr[4];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_last = 1'b1; m_pv = 1'b0; m_ps = 1'b0; m_pw = '0;
    m_v = 1'b0; m_s = 1'b0; m_w = '0; m_err = 1'b0; m_c0 = 0; m_c1 = 0;
  endtask

  task automatic push0(input logic [DW-1:0] w);
    q0.push_back(w);
    D0_empty = 1'b0;
  endtask

  task automatic push1(input logic [DW-1:0] w);
    q1.push_back(w);
    D1_empty = 1'b0;
  endtask

  // One clock cycle: check pops, advance model and FIFOs, check registered outputs.
  task automatic step();
    logic e0, e1, ep0, ep1, p0, p1;
    #1;
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
    ep0 = 1'b0;
    ep1 = 1'b0;
    if (m_mode == 1 && enable && !hold) begin
      if (!e0 && !e1) begin
        ep0 = m_last;
        ep1 = !m_last;
      end else begin
        ep0 = !e0;
        ep1 = !e1;
      end
    end
    chk("pop_D0", pop_D0, ep0);
    chk("pop_D1", pop_D1, ep1);
    p0 = pop_D0;
    p1 = pop_D1;
    if (p0) n_pop0++;
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      m_v = m_pv;
      if (m_pv) begin
        m_w = m_pw;
        m_s = m_ps;
        src_log.push_back(m_ps);
        if (m_ps) m_c1 = (m_c1 + 1) % (1 << CW);
        else      m_c0 = (m_c0 + 1) % (1 << CW);
        if (m_pw[4] != m_ps) m_err = 1'b1;
      end
      m_pv = ep0 | ep1;
      if (ep0) begin
        m_ps = 1'b0; m_pw = q0[0]; m_last = 1'b0;
      end else if (ep1) begin
        m_ps = 1'b1; m_pw = q1[0]; m_last = 1'b1;
      end
      case (m_mode)
        0:       if (enable && !(e0 && e1)) m_mode = 1;
        1:       if (!enable || (e0 && e1)) m_mode = 2;
        default: m_mode = (enable && !(e0 && e1)) ? 1 : 0;
      endcase
    end
    #1;
    if (p0 && q0.size() > 0) data_out0 = q0.pop_front();
    if (p1 && q1.size() > 0) data_out1 = q1.pop_front();
    D0_empty = (q0.size() == 0);
    D1_empty = (q1.size() == 0);
    @(negedge clk);
    chk("word_valid", word_valid, m_v);
    chk("word_out", word_out, m_w);
    chk("word_src", word_src, m_s);
    chk("count_D0", count_D0, m_c0);
    chk("count_D1", count_D1, m_c1);
    chk("route_err", route_err, m_err);
    chk("drain_idle", drain_idle, (m_mode == 0));
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; hold = 1'b0;
    D0_empty = 1'b1; D1_empty = 1'b1;
    data_out0 = '0; data_out1 = '0;
    model_reset();
    @(negedge clk);

    // reset held, then idle with empty FIFOs
    repeat (5) step();
    reset = 1'b1;
    enable = 1'b1;
    n_pop0 = 0;
    repeat (10) step();
    chk("idle_pops", n_pop0, 0);
    chk("idle_drain_idle", drain_idle, 1);
    chk("idle_word_out", word_out, 0);

    // round-robin: first tie goes to D0
    src_log.delete();
    push0(6'h02); push0(6'h03); push1(6'h12); push1(6'h13);
    repeat (8) step();
    exp_rr[0] = 1'b0; exp_rr[1] = 1'b1; exp_rr[2] = 1'b0; exp_rr[3] = 1'b1;
    chk("rr_len", src_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < src_log.size()) chk("rr_src", src_log[i], exp_rr[i]);
    end
    chk("rr_count_D0", count_D0, 2);
    chk("rr_count_D1", count_D1, 2);

    // single-destination stream of 15 words
    n_pop0 = 0;
    for (int i = 1; i <= 15; i++) push0(6'(i));
    repeat (20) step();
    chk("stream_pops", n_pop0, 15);
    chk("stream_count_D0", count_D0, 17);
    chk("stream_word_out", word_out, 6'h0F);
    chk("stream_route_err", route_err, 0);

    // backpressure then disable with a word in flight
    for (int i = 1; i <= 6; i++) push0(6'(32 + i));
    repeat (4) step();
    hold = 1'b1;
    n_pop0 = 0;
    repeat (3) step();
    chk("hold_pops", n_pop0, 0);
    hold = 1'b0;
    step();
    enable = 1'b0;
    repeat (3) step();
    chk("dis_drain_idle", drain_idle, 1);
    chk("dis_count_D0", count_D0, 21);
    chk("dis_word_out", word_out, 6'h24);
    chk("dis_left", q0.size(), 2);
    enable = 1'b1;
    repeat (6) step();
    chk("bp_count_D0", count_D0, 23);

    // misrouted word sets a sticky error
    push0(6'h15);
    repeat (5) step();
    chk("route_err_set", route_err, 1);
    repeat (3) step();
    chk("route_err_sticky", route_err, 1);
    chk("route_count_D0", count_D0, 24);

    // clean reset, then wrap the D1 counter
    reset = 1'b0;
    model_reset();
    step();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) push1(6'(16 + (i % 16)));
    repeat (262) step();
    chk("wrap_count_D1", count_D1, 0);
    chk("wrap_count_D0", count_D0, 0);
    chk("wrap_route_err", route_err, 0);

    // asynchronous reset with a word in flight
    for (int i = 0; i < 4; i++) push1(6'(24 + i));
    repeat (3) step();
    chk("pre_rst_count_D1", count_D1, 1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_pop_D1", pop_D1, 0);
    chk("rst_count_D1", count_D1, 0);
    chk("rst_drain_idle", drain_idle, 1);
    step();
    chk("rst_no_valid", word_valid, 0);
    reset = 1'b1;
    repeat (6) step();
    chk("post_rst_count_D1", count_D1, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/d_fifo_drain.md
# d_fifo_drain

Drain engine on the output side of the device. It pops words from the two destination FIFOs (D0, D1), which until now only the bench drove by hand. It arbitrates round-robin between them and presents each word on a single registered output stream tagged with its source. It also counts words per destination and flags any word whose destination field disagrees with the FIFO it came from.

## Interface
Parameters:
- DATA_W, 6, word width; must equal device data width.
- CNT_W, 8, width of per-destination word counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces every register to its reset value immediately.
- enable  in  1  1 = drain allowed; 0 = no new pops (words already in flight still complete).
- hold  in  1  downstream backpressure; 1 = no new pops this cycle.
- D0_empty  in  1  D0 FIFO empty flag; reflects a pop on the cycle after that pop's edge.
- D1_empty  in  1  D1 FIFO empty flag; same semantics as D0_empty.
- data_out0  in  DATA_W  D0 read data; valid the cycle after pop_D0.
- data_out1  in  DATA_W  D1 read data; valid the cycle after pop_D1.
- pop_D0  out  1  combinational pop to D0.
- pop_D1  out  1  combinational pop to D1.
- word_out  out  DATA_W  registered captured word.
- word_valid  out  1  1-cycle pulse; word_out is valid.
- word_src  out  1  0 = word came from D0; 1 = word came from D1.
- count_D0  out  CNT_W  words drained from D0, modulo 2^CNT_W.
- count_D1  out  CNT_W  words drained from D1, modulo 2^CNT_W.
- route_err  out  1  sticky; set on destination mismatch.
- drain_idle  out  1  1 when state is IDLE.

## Operation
- Destination field: bit 4 of a word. D0 words must have bit4 = 0; D1 words must have bit4 = 1.
- FSM states:
  - IDLE: no pops. Go to DRAIN when enable=1 and either FIFO is non-empty.
  - DRAIN: pop per the arbitration rules below. Go to FLUSH when enable=0, or when both FIFOs are empty.
  - FLUSH: no pops. Wait for the in-flight word to be captured. If a FIFO is non-empty and enable=1, return to DRAIN; otherwise return to IDLE.
- Arbitration (DRAIN only, and only when hold=0):
  - At most one pop per cycle.
  - If only one FIFO is non-empty, pop it.
  - If both are non-empty, pop the FIFO not served last.
  - last_served register: reset value 1, so D0 wins the first tie.
- pop_Dx is never asserted while Dx_empty=1, in any state.
- Capture stage:
  - A registered flag in_flight and a source bit are set on the cycle a pop is issued.
  - On the next edge, latch word_out from the selected data_outX, set word_src, and assert word_valid for 1 cycle.
  - On that same edge, increment the matching counter (wraps 2^CNT_W−1 → 0).
  - On that same edge, compare bit4 with the source; on mismatch, set route_err.
- route_err stays set until reset.
- Back-to-back pops give one word_valid per cycle.

## Timing
- Reset values: pop_D0=0, pop_D1=0, word_out=0, word_valid=0, word_src=0, count_D0=0, count_D1=0, route_err=0, drain_idle=1, state=IDLE, in_flight=0.
- Latency: pop at edge N → word_valid, word_out, and counter update visible after edge N+1.
- hold=1 takes effect in the same cycle: the pop is suppressed combinationally.
- enable deasserted: DRAIN→FLUSH at the next edge. A word popped in the last DRAIN cycle is still delivered.
- IDLE→DRAIN costs 1 cycle: the first pop occurs in the cycle after the FIFO became non-empty.
- Single word in a FIFO: exactly one pop, because the empty flag rises before the next pop decision.
- Reset asserted mid-transfer: the in-flight word is discarded, word_valid does not pulse, and counters clear.

## Test plan
- Reset/idle: hold reset=0 for 5 cycles, then release, with both FIFOs empty → all outputs at reset values, drain_idle=1, no pops for 10 cycles.
- Single-destination stream: push words 0x01..0x0F (bit4=0) into D0 only, enable=1 → 15 consecutive pop_D0 pulses, word_out follows 0x01..0x0F one cycle after each pop, count_D0=15, route_err=0.
- Round-robin: D0 holds {0x02, 0x03} and D1 holds {0x12, 0x13} → pop order D0, D1, D0, D1; word_src sequence 0, 1, 0, 1; count_D0=2, count_D1=2.
- Backpressure and disable: hold=1 for 3 cycles mid-stream → no pops during those cycles, no words lost. Deassert enable with a pop in flight → that word is still delivered, state passes FLUSH→IDLE, drain_idle=1.
- Route error and wrap: D0 supplies 0x15 (bit4=1) → route_err=1 on the capture cycle and stays 1. Drain 256 D1 words → count_D1 wraps to 0.
- Async reset mid-drain: reset=0 between an edge and the next → pops drop to 0 immediately, next edge gives no word_valid, counters read 0.
